// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths,
// used by both the APB requester and the APB completer.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 32;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS wait-cycle counter for the APB requester; only instantiated
// when APB_MASTER_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Expires on the TIMEOUT-th wait cycle, counting the current one.
  assign o_expired = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command stream into APB transfers and
// returns one response pulse per transfer. Optional abort: APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int addrWidth = APB_ADDR_WIDTH,
  parameter int dataWidth = APB_DATA_WIDTH,
  parameter int TIMEOUT   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESENTn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [addrWidth-1:0] PADDR,
  output logic                 PWRITE,
  output logic                 PSELx,
  output logic                 PENABLE,
  output logic [dataWidth-1:0] PWDATA,
  input  logic [dataWidth-1:0] PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  apb_state_e r_state;
  apb_state_e w_next_state;

  logic [addrWidth-1:0] r_paddr;
  logic                 r_pwrite;
  logic [dataWidth-1:0] r_pwdata;
  logic                 r_rsp_valid;
  logic [dataWidth-1:0] r_rsp_rdata;
  logic                 r_rsp_err;

  logic w_ready;
  logic w_accept;
  logic w_complete;
  logic w_abort;

`ifdef APB_MASTER_TIMEOUT_EN
  logic w_expired;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .i_clk     (PCLK),
    .i_rst_n   (PRESENTn),
    .i_clear   (r_state == SETUP),
    .i_count   ((r_state == ACCESS) && !PREADY),
    .o_expired (w_expired)
  );

  assign w_abort = w_expired && (r_state == ACCESS) && !PREADY;
`else
  // Without the counter a stalled completer is waited on forever.
  assign w_abort = 1'b0 && (TIMEOUT > 0);
`endif

  always_ff @(posedge PCLK or negedge PRESENTn) begin
    if (!PRESENTn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (cmd_valid) begin
          w_next_state = SETUP;
        end
      end
      SETUP: begin
        w_next_state = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          w_ready      = 1'b1;
          w_complete   = 1'b1;
          w_next_state = cmd_valid ? SETUP : IDLE;
        end else if (w_abort) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_accept = cmd_valid && w_ready;

  // PWDATA returns to zero whenever the bus goes idle; PADDR/PWRITE keep their value.
  always_ff @(posedge PCLK or negedge PRESENTn) begin
    if (!PRESENTn) begin
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_wdata;
      end else if (w_complete || w_abort) begin
        r_pwdata <= '0;
      end
      r_rsp_valid <= w_complete || w_abort;
      r_rsp_rdata <= (w_complete && !r_pwrite) ? PRDATA : '0;
      r_rsp_err   <= w_complete ? PSLVERR : w_abort;
    end
  end

  assign cmd_ready = w_ready && PRESENTn;
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign PSELx     = (r_state != IDLE);
  assign PENABLE   = (r_state == ACCESS);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: behavioural APB completer with
// per-transfer wait states and errors, plus a response scoreboard.
module tb_apb_master;

  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    int   waits;
    logic err;
  } cfg_t;

  logic          PCLK = 1'b0;
  logic          PRESENTn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic          PSELx;
  logic          PENABLE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int   checksTotal  = 0;
  int   checksPassed = 0;
  int   rspCount     = 0;
  rsp_t sbq[$];
  cfg_t cplq[$];
  logic [31:0] mem [0:255];

  always #5 PCLK = ~PCLK;

  apb_master #(
    .addrWidth (AW),
    .dataWidth (DW),
    .TIMEOUT   (4)
  ) dut (
    .PCLK      (PCLK),
    .PRESENTn  (PRESENTn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offer one command and hold it until accepted; queue its expected response.
  task automatic applyStimulus(input vec_t v);
    int bound;
    bound     = 0;
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    #1;
    while (!cmd_ready && bound < 200) begin
      @(negedge PCLK);
      #1;
      bound++;
    end
    if (!cmd_ready) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
    end else begin
      sbq.push_back(rsp_t'{v.expRdata, v.expErr});
      cplq.push_back(cfg_t'{v.waits, v.slverr});
    end
    @(negedge PCLK);
    #1;
  endtask

  task automatic nextCycle();
    @(negedge PCLK);
    #1;
  endtask

  task automatic waitDrain();
    int bound;
    bound = 0;
    while (sbq.size() > 0 && bound < 100) begin
      nextCycle();
      bound++;
    end
    checkOutput("drainQueue", sbq.size(), 32'd0);
  endtask

  // Completer: drives garbage outside ACCESS, wait states and errors per transfer.
  initial begin
    int          curWaits;
    logic        curErr;
    logic [7:0]  capAddr;
    logic [31:0] capData;
    logic        capWrite;
    cfg_t        c;
    curWaits = 0;
    curErr   = 1'b0;
    capAddr  = '0;
    capData  = '0;
    capWrite = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    PREADY  = 1'b1;
    PRDATA  = '0;
    PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PRESENTn && PSELx && PENABLE) begin
        checkOutput("accessPaddrStable", PADDR, capAddr);
        checkOutput("accessPwdataStable", PWDATA, capData);
        checkOutput("accessPwriteStable", PWRITE, capWrite);
        if (curWaits > 0) begin
          curWaits--;
          PREADY  = 1'b0;
          PRDATA  = $urandom;
          PSLVERR = 1'($urandom_range(0, 1));
        end else begin
          PREADY  = 1'b1;
          PSLVERR = curErr;
          if (PWRITE) begin
            mem[PADDR] = PWDATA;
            PRDATA     = $urandom;
          end else begin
            PRDATA = mem[PADDR];
          end
        end
      end else begin
        if (PRESENTn && PSELx) begin
          if (cplq.size() > 0) begin
            c        = cplq.pop_front();
            curWaits = c.waits;
            curErr   = c.err;
          end else begin
            curWaits = 0;
            curErr   = 1'b0;
          end
          capAddr  = PADDR;
          capData  = PWDATA;
          capWrite = PWRITE;
        end
        PREADY  = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom_range(0, 1));
      end
    end
  end

  // Scoreboard: every rsp_valid pulse consumes one expected response.
  initial begin
    rsp_t e;
    forever begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          checkOutput("rspUnexpected", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          checkOutput("rspRdata", rsp_rdata, e.rdata);
          checkOutput("rspErr", rsp_err, e.err);
          rspCount++;
        end
      end else begin
        checkOutput("rspIdleZero", rsp_rdata | {31'b0, rsp_err}, 32'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    vec_t v;
    int   selRun;
    int   pulses;
    int   bound;
    int   accCycles;
    int   rspBefore;

    vecs[0] = '{1'b1, 8'h3F, 32'h5A5A5A5A, 0, 1'b0, 32'h00000000, 1'b0};
    vecs[1] = '{1'b0, 8'h3F, 32'h00000000, 0, 1'b0, 32'h5A5A5A5A, 1'b0};
    vecs[2] = '{1'b1, 8'h20, 32'h12345678, 3, 1'b0, 32'h00000000, 1'b0};
    vecs[3] = '{1'b0, 8'h20, 32'hFFFFFFFF, 1, 1'b0, 32'h12345678, 1'b0};
    vecs[4] = '{1'b0, 8'h3F, 32'h00000000, 2, 1'b1, 32'h5A5A5A5A, 1'b1};
    vecs[5] = '{1'b1, 8'h22, 32'hCAFEF00D, 0, 1'b1, 32'h00000000, 1'b1};
    vecs[6] = '{1'b0, 8'h55, 32'h00000000, 0, 1'b0, 32'h00000000, 1'b0};
    vecs[7] = '{1'b0, 8'h10, 32'h00000000, 0, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[8] = '{1'b1, 8'h80, 32'h0BADF00D, 5, 1'b0, 32'h00000000, 1'b0};

    PRESENTn  = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (2) nextCycle();

    checkOutput("resetPsel", PSELx, 32'd0);
    checkOutput("resetPenable", PENABLE, 32'd0);
    checkOutput("resetPaddr", PADDR, 32'd0);
    checkOutput("resetPwdata", PWDATA, 32'd0);
    checkOutput("resetPwrite", PWRITE, 32'd0);
    checkOutput("resetCmdReady", cmd_ready, 32'd0);
    checkOutput("resetRspValid", rsp_valid, 32'd0);

    PRESENTn = 1'b1;
    nextCycle();
    checkOutput("releaseCmdReady", cmd_ready, 32'd1);

    $display("[TB] single write");
    v = '{1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0, 1'b0};
    applyStimulus(v);
    cmd_valid = 1'b0;
    checkOutput("setupPsel", PSELx, 32'd1);
    checkOutput("setupPenable", PENABLE, 32'd0);
    checkOutput("setupPaddr", PADDR, 32'h10);
    checkOutput("setupPwdata", PWDATA, 32'hDEADBEEF);
    checkOutput("setupPwrite", PWRITE, 32'd1);
    checkOutput("setupCmdReady", cmd_ready, 32'd0);
    nextCycle();
    checkOutput("accessPsel", PSELx, 32'd1);
    checkOutput("accessPenable", PENABLE, 32'd1);
    checkOutput("accessCmdReady", cmd_ready, 32'd1);
    checkOutput("accessRspValid", rsp_valid, 32'd0);
    nextCycle();
    checkOutput("singleRspValid", rsp_valid, 32'd1);
    checkOutput("idlePsel", PSELx, 32'd0);
    checkOutput("idlePenable", PENABLE, 32'd0);
    checkOutput("idlePwdata", PWDATA, 32'd0);
    checkOutput("idlePaddrHeld", PADDR, 32'h10);
    checkOutput("idlePwriteHeld", PWRITE, 32'd1);
    nextCycle();
    checkOutput("singleRspPulse", rsp_valid, 32'd0);

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      if (i % 2 == 0) begin
        cmd_valid = 1'b0;
        nextCycle();
      end
    end
    cmd_valid = 1'b0;
    waitDrain();

    $display("[TB] back-to-back writes");
    selRun = 0;
    pulses = 0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          v = '{1'b1, 8'(k), 32'hB0B00000 | 32'(k), 0, 1'b0, 32'h0, 1'b0};
          applyStimulus(v);
        end
        cmd_valid = 1'b0;
      end
      begin
        bound = 0;
        nextCycle();
        while (!PSELx && bound < 20) begin
          nextCycle();
          bound++;
        end
        while (PSELx && selRun < 40) begin
          selRun++;
          if (rsp_valid) pulses++;
          nextCycle();
        end
        if (rsp_valid) pulses++;
      end
    join
    checkOutput("b2bSelCycles", selRun, 32'd8);
    checkOutput("b2bRspPulses", pulses, 32'd4);
    waitDrain();
    v = '{1'b0, 8'h02, 32'h0, 0, 1'b0, 32'hB0B00002, 1'b0};
    applyStimulus(v);
    cmd_valid = 1'b0;
    waitDrain();

    $display("[TB] reset during ACCESS");
    v = '{1'b0, 8'h3F, 32'h0, 1000, 1'b0, 32'h5A5A5A5A, 1'b0};
    applyStimulus(v);
    cmd_valid = 1'b0;
    nextCycle();
    checkOutput("preResetPenable", PENABLE, 32'd1);
    PRESENTn = 1'b0;
    #1;
    sbq.delete();
    cplq.delete();
    rspBefore = rspCount;
    checkOutput("midResetPsel", PSELx, 32'd0);
    checkOutput("midResetPenable", PENABLE, 32'd0);
    checkOutput("midResetPaddr", PADDR, 32'd0);
    checkOutput("midResetPwdata", PWDATA, 32'd0);
    checkOutput("midResetCmdReady", cmd_ready, 32'd0);
    checkOutput("midResetRsp", {30'b0, rsp_valid, rsp_err} | rsp_rdata, 32'd0);
    nextCycle();
    PRESENTn = 1'b1;
    nextCycle();
    checkOutput("postResetCmdReady", cmd_ready, 32'd1);
    checkOutput("postResetPsel", PSELx, 32'd0);
    repeat (3) nextCycle();
    checkOutput("postResetNoRsp", rspCount, rspBefore);

`ifdef APB_MASTER_TIMEOUT_EN
    $display("[TB] timeout abort");
    v = '{1'b0, 8'h3F, 32'h0, 1000, 1'b0, 32'h0, 1'b1};
    applyStimulus(v);
    cmd_valid = 1'b0;
    accCycles = 0;
    nextCycle();
    while (PENABLE && accCycles < 50) begin
      accCycles++;
      nextCycle();
    end
    checkOutput("timeoutAccessCycles", accCycles, 32'd4);
    checkOutput("timeoutPsel", PSELx, 32'd0);
    checkOutput("timeoutRspValid", rsp_valid, 32'd1);
    checkOutput("timeoutRspErr", rsp_err, 32'd1);
    waitDrain();
`else
    $display("[TB] stalled completer");
    v = '{1'b0, 8'h3F, 32'h0, 1000, 1'b0, 32'h0, 1'b0};
    rspBefore = rspCount;
    applyStimulus(v);
    cmd_valid = 1'b0;
    accCycles = 0;
    repeat (30) begin
      nextCycle();
      if (PENABLE) accCycles++;
    end
    checkOutput("stallAccessCycles", accCycles, 32'd30);
    checkOutput("stallNoRsp", rspCount, rspBefore);
    PRESENTn = 1'b0;
    #1;
    sbq.delete();
    cplq.delete();
    nextCycle();
    PRESENTn = 1'b1;
    nextCycle();
    checkOutput("stallRecoverReady", cmd_ready, 32'd1);
`endif

    repeat (3) nextCycle();
    checkOutput("finalQueueEmpty", sbq.size(), 32'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter addrWidth, default 8, meaning the PADDR and cmd_addr width.
REQ-002 SHALL have parameter dataWidth, default 32, meaning the data width of all data buses.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the maximum ACCESS wait cycles before abort; used only with APB_MASTER_TIMEOUT_EN.
REQ-004 SHALL have port PCLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port PRESENTn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-007 SHALL have port cmd_ready, output, 1 bit: a command is accepted when cmd_valid and cmd_ready are both high at a PCLK edge.
REQ-008 SHALL have ports cmd_write (input, 1 bit), cmd_addr (input, addrWidth bits) and cmd_wdata (input, dataWidth bits): the command fields.
REQ-009 SHALL have port rsp_valid, output, 1 bit: one-cycle response pulse; there is no backpressure.
REQ-010 SHALL have ports rsp_rdata (output, dataWidth bits) and rsp_err (output, 1 bit): read data, and error/timeout flag.
REQ-011 SHALL have ports PADDR (addrWidth), PWRITE (1), PSELx (1), PENABLE (1) and PWDATA (dataWidth), all outputs: the APB requester signals.
REQ-012 SHALL have ports PRDATA (input, dataWidth bits), PREADY (input, 1 bit) and PSLVERR (input, 1 bit): the completer response.

Function
REQ-013 SHALL implement states IDLE, SETUP and ACCESS.
REQ-014 SHALL drive cmd_ready high in IDLE, and in ACCESS during a cycle with PREADY=1; cmd_ready SHALL be low otherwise.
REQ-015 SHALL, on acceptance, register the cmd fields onto PADDR, PWRITE and PWDATA and enter SETUP on the next cycle: PSELx=1, PENABLE=0.
REQ-016 SHALL go from SETUP to ACCESS unconditionally after one cycle: PSELx=1, PENABLE=1, with PADDR, PWRITE and PWDATA held stable.
REQ-017 SHALL, in ACCESS with PREADY=0, stay in ACCESS with all outputs held (a wait state).
REQ-018 SHALL, in ACCESS with PREADY=1, complete: next state is SETUP if a command is accepted in the same cycle, otherwise IDLE.
REQ-019 SHALL keep PSELx high on a back-to-back completion into SETUP; PENABLE SHALL drop to 0.
REQ-020 SHALL assert rsp_valid for exactly one cycle, the cycle after completion.
REQ-021 SHALL, with that pulse, present rsp_rdata = PRDATA sampled at completion for reads, and 0 for writes.
REQ-022 SHALL present rsp_err = PSLVERR sampled at completion.
REQ-023 SHALL hold rsp_rdata and rsp_err at 0 whenever rsp_valid=0.
REQ-024 SHALL drive PSELx=0, PENABLE=0 and PWDATA=0 in IDLE; PADDR and PWRITE SHALL keep their last value.
REQ-025 SHALL sustain throughput of one transfer per 2 cycles with PREADY=1 and back-to-back commands.
REQ-026 SHALL ignore cmd_* inputs while cmd_ready=0.
REQ-027 SHALL ignore PRDATA, PREADY and PSLVERR outside ACCESS.

Reset
REQ-028 SHALL, on PRESENTn=0, asynchronously force state IDLE and clear PADDR, PWRITE, PSELx, PENABLE, PWDATA, cmd_ready, rsp_valid, rsp_rdata, rsp_err and the timeout counter to 0.
REQ-029 SHALL, if reset asserts mid-transfer, abandon the transfer with no rsp_valid; after release the block SHALL be in IDLE with cmd_ready=1 on the first PCLK edge.

Configuration
REQ-030 SHALL, with macro APB_MASTER_TIMEOUT_EN defined, count ACCESS wait cycles.
REQ-031 SHALL, when that count reaches TIMEOUT with PREADY still 0, abort: go to IDLE, pulse rsp_valid with rsp_err=1 and rsp_rdata=0, and SHALL NOT accept a command in that cycle.
REQ-032 SHALL reset the timeout counter on entry to ACCESS.
REQ-033 SHALL, with APB_MASTER_TIMEOUT_EN undefined, wait indefinitely for PREADY, and no counter logic SHALL be synthesised.

Structure
REQ-034 SHALL take the state enumeration (IDLE=0, SETUP=1, ACCESS=2, 2 bits) and the default width constants from shared package apb_pkg, which the APB completer also uses.
REQ-035 SHALL optionally place the timeout counter in sub-module apb_timeout_cnt; all other logic SHALL be flat in apb_master.

Verification
REQ-036 Single write: cmd write addr 0x10 data 0xDEADBEEF, PREADY tied 1 -> SETUP then ACCESS with PADDR=0x10, PWDATA=0xDEADBEEF; rsp_valid one cycle later with rsp_err=0.
REQ-037 Write then read through the team's APB completer (PREADY=1): write 0x5A5A5A5A to 0x3F, read 0x3F -> rsp_rdata=0x5A5A5A5A.
REQ-038 Wait states: PREADY held 0 for 3 ACCESS cycles -> PADDR, PWDATA and PENABLE stable throughout; exactly one rsp_valid after PREADY=1.
REQ-039 Back-to-back: 4 writes to 0x00..0x03 with cmd_valid held high -> PSELx never drops; 8 cycles total; 4 rsp_valid pulses.
REQ-040 Error and reset: PSLVERR=1 at completion -> rsp_err=1; separately, PRESENTn pulsed low during ACCESS -> all outputs 0, no rsp_valid, cmd_ready=1 after release.
REQ-041 Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT=4): PREADY stuck 0 -> abort after 4 wait cycles with rsp_err=1, PSELx=0.
